pms_boot_ctrl_slv: RTL and testbench

AXI4-Lite subordinate holding the PMS boot-control registers: boot address, boot mode, fetch enable, and end-of-computation (EOC) with exit status. It sits between the SoC-side AXI-Lite port and the PMS core complex. An external host, or the simulation boot driver, uses it to configure boot, release the cores and poll for completion. It answers that initiator's write and read sequences; the cores report EOC through a sideband strobe.

---
 rtl/pms_boot_ctrl_pkg.sv | 38 +++
 rtl/pms_boot_ctrl_slv.sv | 194 +++++++++++++++++++
 tb/tb_pms_boot_ctrl_slv.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pms_boot_ctrl_pkg.sv
// Shared definitions for the PMS boot-control AXI4-Lite register block:
// register offsets, response codes, FSM state types and the byte-strobe merge.
package pms_boot_ctrl_pkg;

  localparam logic [3:0] OFS_BOOT_ADDR  = 4'h0;
  localparam logic [3:0] OFS_BOOTMODE   = 4'h4;
  localparam logic [3:0] OFS_FETCH_EN   = 4'h8;
  localparam logic [3:0] OFS_EOC_STATUS = 4'hC;

  localparam int unsigned BOOTMODE_W = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pms_boot_ctrl_slv.sv
// AXI4-Lite subordinate holding PMS boot address, boot mode, fetch enable and
// the end-of-computation status; independent write and read FSMs.
module pms_boot_ctrl_slv
  import pms_boot_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter logic [31:0] BootAddrRst = 32'h1C00_8080
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [AddrWidth-1:0]  aw_addr_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [31:0]           w_data_i,
  input  logic [3:0]            w_strb_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  output logic [1:0]            b_resp_o,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  input  logic [AddrWidth-1:0]  ar_addr_i,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  output logic [31:0]           r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  input  logic                  eoc_valid_i,
  input  logic [30:0]           exit_status_i,
  output logic [31:0]           boot_addr_o,
  output logic [BOOTMODE_W-1:0] bootmode_o,
  output logic                  fetch_en_o,
  output logic                  eoc_o
);

  wr_state_e             wr_q, wr_d;
  rd_state_e             rd_q, rd_d;
  logic [AddrWidth-1:0]  aw_addr_q, aw_addr_d;
  logic [31:0]           w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic [31:0]           r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic [31:0]           boot_addr_q, boot_addr_d;
  logic [BOOTMODE_W-1:0] bootmode_q, bootmode_d;
  logic                  fetch_en_q, fetch_en_d;
  logic                  eoc_q, eoc_d;
  logic [30:0]           exit_q, exit_d;

  logic                  aw_hs, w_hs, commit, wr_mapped, rd_mapped;
  logic [AddrWidth-1:0]  wr_addr;
  logic [31:0]           wr_data, merged, rd_mux;
  logic [3:0]            wr_strb;
  logic                  unused_addr_bits;

  assign aw_ready_o = (wr_q == WR_IDLE) || (wr_q == WR_HAVE_W);
  assign w_ready_o  = (wr_q == WR_IDLE) || (wr_q == WR_HAVE_AW);
  assign b_valid_o  = (wr_q == WR_RESP);
  assign b_resp_o   = b_resp_q;
  assign ar_ready_o = (rd_q == RD_IDLE);
  assign r_valid_o  = (rd_q == RD_RESP);
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;

  assign boot_addr_o = boot_addr_q;
  assign bootmode_o  = bootmode_q;
  assign fetch_en_o  = fetch_en_q;
  assign eoc_o       = eoc_q;

  assign aw_hs = aw_valid_i && aw_ready_o;
  assign w_hs  = w_valid_i && w_ready_o;

  // The second handshake may take its partner from the buffer or the live bus.
  assign wr_addr   = (wr_q == WR_HAVE_AW) ? aw_addr_q : aw_addr_i;
  assign wr_data   = (wr_q == WR_HAVE_W) ? w_data_q : w_data_i;
  assign wr_strb   = (wr_q == WR_HAVE_W) ? w_strb_q : w_strb_i;
  assign wr_mapped = (wr_addr[AddrWidth-1:4] == '0);
  assign rd_mapped = (ar_addr_i[AddrWidth-1:4] == '0);
  assign unused_addr_bits = ^{wr_addr[1:0], ar_addr_i[1:0]};

  always_comb begin
    wr_d      = wr_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    commit    = 1'b0;
    unique case (wr_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_d   = WR_RESP;
          commit = 1'b1;
        end else if (aw_hs) begin
          wr_d      = WR_HAVE_AW;
          aw_addr_d = aw_addr_i;
        end else if (w_hs) begin
          wr_d     = WR_HAVE_W;
          w_data_d = w_data_i;
          w_strb_d = w_strb_i;
        end
      end
      WR_HAVE_AW: if (w_hs) begin
        wr_d   = WR_RESP;
        commit = 1'b1;
      end
      WR_HAVE_W: if (aw_hs) begin
        wr_d   = WR_RESP;
        commit = 1'b1;
      end
      WR_RESP: if (b_ready_i) wr_d = WR_IDLE;
      default: wr_d = WR_IDLE;
    endcase
  end

  always_comb begin
    boot_addr_d = boot_addr_q;
    bootmode_d  = bootmode_q;
    fetch_en_d  = fetch_en_q;
    eoc_d       = eoc_q;
    exit_d      = exit_q;
    b_resp_d    = b_resp_q;
    merged      = strb_merge(boot_addr_q, wr_data, wr_strb);
    if (commit) begin
      b_resp_d = wr_mapped ? RESP_OKAY : RESP_SLVERR;
      if (wr_mapped) begin
        unique case (wr_addr[3:2])
          OFS_BOOT_ADDR[3:2]:  boot_addr_d = merged;
          OFS_BOOTMODE[3:2]:   if (wr_strb[0]) bootmode_d = wr_data[BOOTMODE_W-1:0];
          OFS_FETCH_EN[3:2]:   if (wr_strb[0]) fetch_en_d = wr_data[0];
          OFS_EOC_STATUS[3:2]: if (wr_strb[3] && wr_data[31]) eoc_d = 1'b0;
          default: ;
        endcase
      end
    end
    // A completion strobe overrides a clear landing on the same edge.
    if (eoc_valid_i) begin
      eoc_d  = 1'b1;
      exit_d = exit_status_i;
    end
  end

  always_comb begin
    unique case (ar_addr_i[3:2])
      OFS_BOOT_ADDR[3:2]: rd_mux = boot_addr_q;
      OFS_BOOTMODE[3:2]:  rd_mux = {{(32-BOOTMODE_W){1'b0}}, bootmode_q};
      OFS_FETCH_EN[3:2]:  rd_mux = {31'b0, fetch_en_q};
      default:            rd_mux = {eoc_q, exit_q};
    endcase
    rd_d     = rd_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    if (rd_q == RD_IDLE) begin
      if (ar_valid_i) begin
        rd_d     = RD_RESP;
        r_data_d = rd_mapped ? rd_mux : 32'h0;
        r_resp_d = rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end
    end else if (r_ready_i) begin
      rd_d = RD_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q        <= WR_IDLE;
      rd_q        <= RD_IDLE;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      b_resp_q    <= RESP_OKAY;
      r_data_q    <= '0;
      r_resp_q    <= RESP_OKAY;
      boot_addr_q <= BootAddrRst;
      bootmode_q  <= '0;
      fetch_en_q  <= 1'b0;
      eoc_q       <= 1'b0;
      exit_q      <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      aw_addr_q   <= aw_addr_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      b_resp_q    <= b_resp_d;
      r_data_q    <= r_data_d;
      r_resp_q    <= r_resp_d;
      boot_addr_q <= boot_addr_d;
      bootmode_q  <= bootmode_d;
      fetch_en_q  <= fetch_en_d;
      eoc_q       <= eoc_d;
      exit_q      <= exit_d;
    end
  end

endmodule

// File: tb/tb_pms_boot_ctrl_slv.sv
// Directed bench for pms_boot_ctrl_slv: register-level model checked every cycle
// plus hand-computed expectations for boot, ordering, EOC, unmapped and reset cases.
module tb_pms_boot_ctrl_slv;

  logic        clk;
  logic        rst_ni;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp, r_resp;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic        eoc_valid, fetch_en, eoc;
  logic [30:0] exit_status;
  logic [31:0] boot_addr;
  logic [1:0]  bootmode;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  logic [31:0] m_boot;
  logic [1:0]  m_mode;
  logic        m_fetch, m_eoc;
  logic [30:0] m_exit;

  pms_boot_ctrl_slv dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
    .eoc_valid_i(eoc_valid), .exit_status_i(exit_status),
    .boot_addr_o(boot_addr), .bootmode_o(bootmode), .fetch_en_o(fetch_en), .eoc_o(eoc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 32'h1C00_8080; m_mode = 2'b00; m_fetch = 1'b0; m_eoc = 1'b0; m_exit = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:4] != 28'h0) return 32'h0;
    case (a[3:2])
      2'd0:    return m_boot;
      2'd1:    return {30'b0, m_mode};
      2'd2:    return {31'b0, m_fetch};
      default: return {m_eoc, m_exit};
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r);
    logic [31:0] m, cur;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (a[31:4] != 28'h0) begin
      r = 2'b10;
    end else begin
      r = 2'b00;
      case (a[3:2])
        2'd0: m_boot = (m_boot & ~m) | (d & m);
        2'd1: begin cur = ({30'b0, m_mode} & ~m) | (d & m); m_mode = cur[1:0]; end
        2'd2: begin cur = ({31'b0, m_fetch} & ~m) | (d & m); m_fetch = cur[0]; end
        default: if (s[3] && d[31]) m_eoc = 1'b0;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("boot_addr_o", boot_addr, m_boot);
      chk("bootmode_o", 32'(bootmode), 32'(m_mode));
      chk("fetch_en_o", 32'(fetch_en), 32'(m_fetch));
      chk("eoc_o", 32'(eoc), 32'(m_eoc));
    end
  end

  // order: 0 = AW and W together, 1 = W one cycle before AW, 2 = AW before W.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int order, input int bhold, input logic with_eoc,
                           input logic [30:0] st, output logic [1:0] resp);
    logic [1:0] exp_resp;
    aw_addr = a; w_data = d; w_strb = s;
    if (order == 1) begin
      w_valid = 1'b1; @(posedge clk); #1 w_valid = 1'b0;
    end else if (order == 2) begin
      aw_valid = 1'b1; @(posedge clk); #1 aw_valid = 1'b0;
    end
    aw_valid = (order != 2); w_valid = (order != 1);
    eoc_valid = with_eoc; exit_status = st;
    @(posedge clk);
    #1 aw_valid = 1'b0; w_valid = 1'b0; eoc_valid = 1'b0;
    model_write(a, d, s, exp_resp);
    if (with_eoc) begin m_eoc = 1'b1; m_exit = st; end
    @(negedge clk);
    chk("b_valid latency", 32'(b_valid), 32'd1);
    chk("b_resp", 32'(b_resp), 32'(exp_resp));
    resp = b_resp;
    for (int i = 0; i < bhold; i++) begin
      chk("b_valid held", 32'(b_valid), 32'd1);
      chk("aw_ready in RESP", 32'(aw_ready), 32'd0);
      chk("w_ready in RESP", 32'(w_ready), 32'd0);
      aw_addr = 32'h0; w_data = 32'hDEAD_BEEF; w_strb = 4'hF;
      aw_valid = 1'b1; w_valid = 1'b1;
      @(negedge clk);
    end
    b_ready = 1'b1;
    @(posedge clk);
    #1 b_ready = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    chk("b_valid after B", 32'(b_valid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    exp_d = model_read(a);
    exp_r = (a[31:4] != 28'h0) ? 2'b10 : 2'b00;
    ar_addr = a; ar_valid = 1'b1;
    @(posedge clk);
    #1 ar_valid = 1'b0;
    @(negedge clk);
    chk("r_valid latency", 32'(r_valid), 32'd1);
    chk("ar_ready in RESP", 32'(ar_ready), 32'd0);
    chk("r_data", r_data, exp_d);
    chk("r_resp", 32'(r_resp), 32'(exp_r));
    d = r_data; resp = r_resp;
    r_ready = 1'b1;
    @(posedge clk);
    #1 r_ready = 1'b0;
    @(negedge clk);
    chk("r_valid after R", 32'(r_valid), 32'd0);
  endtask

  task automatic pulse_eoc(input logic [30:0] st);
    eoc_valid = 1'b1; exit_status = st;
    @(posedge clk);
    #1 eoc_valid = 1'b0;
    m_eoc = 1'b1; m_exit = st;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs, ws;
  logic [31:0] exp_old;

  initial begin
    aw_addr = '0; aw_valid = 0; w_data = '0; w_strb = '0; w_valid = 0; b_ready = 0;
    ar_addr = '0; ar_valid = 0; r_ready = 0; eoc_valid = 0; exit_status = '0;
    model_reset();
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #2;
    chk("rst aw_ready", 32'(aw_ready), 32'd1);
    chk("rst w_ready", 32'(w_ready), 32'd1);
    chk("rst ar_ready", 32'(ar_ready), 32'd1);
    chk("rst b_valid", 32'(b_valid), 32'd0);
    chk("rst r_valid", 32'(r_valid), 32'd0);
    chk("rst b_resp", 32'(b_resp), 32'd0);
    chk("rst r_resp", 32'(r_resp), 32'd0);
    chk("rst r_data", r_data, 32'd0);
    chk("rst boot_addr", boot_addr, 32'h1C00_8080);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    chk_en = 1'b1;

    axi_read(32'h0, rd, rs);
    chk("reset read BOOT_ADDR", rd, 32'h1C00_8080);
    chk("reset read resp", 32'(rs), 32'd0);

    // Boot sequence
    axi_write(32'h4, 32'h3, 4'hF, 0, 0, 1'b0, '0, ws);
    chk("bootmode after write", 32'(bootmode), 32'd3);
    chk("bootmode resp", 32'(ws), 32'd0);
    axi_write(32'h0, 32'h1C00_0880, 4'hF, 0, 0, 1'b0, '0, ws);
    chk("boot_addr after write", boot_addr, 32'h1C00_0880);
    chk("boot_addr resp", 32'(ws), 32'd0);
    axi_write(32'h8, 32'h1, 4'hF, 0, 0, 1'b0, '0, ws);
    chk("fetch_en after write", 32'(fetch_en), 32'd1);
    chk("fetch_en resp", 32'(ws), 32'd0);

    // Channel ordering with back-pressure on B
    axi_write(32'h0, 32'hA5A5_0001, 4'hF, 1, 3, 1'b0, '0, ws);
    chk("W-first commit", boot_addr, 32'hA5A5_0001);
    axi_write(32'h0, 32'h5A5A_0002, 4'hF, 2, 3, 1'b0, '0, ws);
    chk("AW-first commit", boot_addr, 32'h5A5A_0002);
    axi_write(32'h0, 32'h1234_5678, 4'hF, 0, 3, 1'b0, '0, ws);
    chk("same-cycle commit", boot_addr, 32'h1234_5678);

    // EOC set, partial-strobe no-op, clear, set-wins-over-clear
    pulse_eoc(31'h0);
    @(negedge clk);
    chk("eoc_o after pulse", 32'(eoc), 32'd1);
    axi_read(32'hC, rd, rs);
    chk("EOC_STATUS read", rd, 32'h8000_0000);
    axi_write(32'hC, 32'h8000_0000, 4'h7, 0, 0, 1'b0, '0, ws);
    chk("eoc kept without strb3", 32'(eoc), 32'd1);
    axi_write(32'hC, 32'h8000_0000, 4'hF, 0, 0, 1'b0, '0, ws);
    chk("eoc cleared", 32'(eoc), 32'd0);
    axi_write(32'hC, 32'h8000_0000, 4'hF, 0, 0, 1'b1, 31'h5, ws);
    chk("set wins over clear", 32'(eoc), 32'd1);
    axi_read(32'hC, rd, rs);
    chk("EOC_STATUS with code", rd, 32'h8000_0005);

    // Unmapped and strobed accesses
    axi_write(32'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0, '0, ws);
    chk("unmapped write resp", 32'(ws), 32'd2);
    chk("unmapped write no effect", boot_addr, 32'h1234_5678);
    axi_read(32'h14, rd, rs);
    chk("unmapped read data", rd, 32'h0);
    chk("unmapped read resp", 32'(rs), 32'd2);
    axi_write(32'h0, 32'hFFFF_FFAA, 4'b0001, 0, 0, 1'b0, '0, ws);
    chk("byte-0 strobe", boot_addr, 32'h1234_56AA);

    // Concurrent read and write on one edge, then reset with both responses pending
    exp_old = model_read(32'h0);
    aw_addr = 32'h4; w_data = 32'h1; w_strb = 4'hF; ar_addr = 32'h0;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    @(posedge clk);
    #1 aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    model_write(32'h4, 32'h1, 4'hF, ws);
    @(negedge clk);
    chk("concurrent b_valid", 32'(b_valid), 32'd1);
    chk("concurrent r_valid", 32'(r_valid), 32'd1);
    chk("concurrent r_data", r_data, exp_old);
    chk("concurrent r_data literal", r_data, 32'h1234_56AA);
    chk("concurrent bootmode", 32'(bootmode), 32'd1);
    #1 rst_ni = 1'b0;
    model_reset();
    #1;
    chk("mid-rst b_valid", 32'(b_valid), 32'd0);
    chk("mid-rst r_valid", 32'(r_valid), 32'd0);
    chk("mid-rst aw_ready", 32'(aw_ready), 32'd1);
    chk("mid-rst boot_addr", boot_addr, 32'h1C00_8080);
    chk("mid-rst bootmode", 32'(bootmode), 32'd0);
    chk("mid-rst fetch_en", 32'(fetch_en), 32'd0);
    chk("mid-rst eoc", 32'(eoc), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    axi_read(32'hC, rd, rs);
    chk("post-rst EOC_STATUS", rd, 32'h0);
    axi_read(32'h0, rd, rs);
    chk("post-rst BOOT_ADDR", rd, 32'h1C00_8080);

    chk_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
